// File: rtl/dual_issue_fetch_queue_pkg.sv
// Shared pipeline definitions used by the fetch queue and the dual-issue hazard stage.
package dual_issue_fetch_queue_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 presented on an empty issue slot
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/dual_issue_fetch_queue_ram.sv
// DEPTH x 64 entry store: pair write at waddr/waddr+1, async pair read at raddr/raddr+1.
// No reset on contents; validity is tracked by the owner's count.
module dual_issue_fetch_queue_ram
  import dual_issue_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdat0,
  input  fq_entry_t       wdat1,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdat0,
  output fq_entry_t       rdat1
);

  fq_entry_t mem [DEPTH];

  logic [AW-1:0] waddr1;
  logic [AW-1:0] raddr1;

  assign waddr1 = waddr + AW'(1);
  assign raddr1 = raddr + AW'(1);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr]  <= wdat0;
      mem[waddr1] <= wdat1;
    end
  end

  assign rdat0 = mem[raddr];
  assign rdat1 = mem[raddr1];

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// Pair-in, two-slot-out instruction queue; 1-cycle enqueue-to-issue latency, retires 0..2 per cycle.
// fetch_ready drops when fewer than two entries are free; fetch must hold its pair until accepted.
module dual_issue_fetch_queue
  import dual_issue_fetch_queue_pkg::*;
#(
  parameter int              DEPTH     = 8,
  parameter logic [XLEN-1:0] NOP_INSTR = dual_issue_fetch_queue_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr0,
  input  logic [31:0]                fetch_instr1,
  output logic                       fetch_ready,
  input  logic                       flush,
  input  logic [1:0]                 issue_take,
  output logic                       issue_valid1,
  output logic                       issue_valid2,
  output logic [31:0]                issue_instr1,
  output logic [31:0]                issue_instr2,
  output logic [31:0]                issue_pc1,
  output logic [31:0]                issue_pc2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] free_slots;
  logic [1:0]    take_clip;
  logic [1:0]    deq;
  logic          enq;
  fq_entry_t     wdat0, wdat1, rdat0, rdat1;

  assign free_slots  = CW'(DEPTH) - count;
  assign fetch_ready = free_slots >= CW'(2);
  assign enq         = fetch_valid && fetch_ready && !flush;

  // Requests beyond current occupancy are clipped so head never passes tail.
  always_comb begin
    take_clip = (issue_take == 2'd3) ? 2'd2 : issue_take;
    deq       = take_clip;
    if (count < CW'(take_clip))
      deq = count[1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq);
      tail  <= enq ? tail + AW'(2) : tail;
      count <= count + (enq ? CW'(2) : CW'(0)) - CW'(deq);
    end
  end

  assign wdat0 = '{pc: fetch_pc,          instr: fetch_instr0};
  assign wdat1 = '{pc: fetch_pc + 32'd4,  instr: fetch_instr1};

  dual_issue_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdat0 (wdat0),
    .wdat1 (wdat1),
    .raddr (head),
    .rdat0 (rdat0),
    .rdat1 (rdat1)
  );

  assign issue_valid1 = count >= CW'(1);
  assign issue_valid2 = count >= CW'(2);
  assign issue_instr1 = issue_valid1 ? rdat0.instr : NOP_INSTR;
  assign issue_pc1    = issue_valid1 ? rdat0.pc    : 32'd0;
  assign issue_instr2 = issue_valid2 ? rdat1.instr : NOP_INSTR;
  assign issue_pc2    = issue_valid2 ? rdat1.pc    : 32'd0;

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Vector table of fetch/take/flush stimulus with expected occupancy, plus a queue scoreboard for slot contents.
module tb_dual_issue_fetch_queue;

  logic        clk;
  logic        rstn;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic        fetch_ready;
  logic        flush;
  logic [1:0]  issue_take;
  logic        issue_valid1;
  logic        issue_valid2;
  logic [31:0] issue_instr1;
  logic [31:0] issue_instr2;
  logic [31:0] issue_pc1;
  logic [31:0] issue_pc2;
  logic [3:0]  count;

  dual_issue_fetch_queue #(.DEPTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_instr0 (fetch_instr0),
    .fetch_instr1 (fetch_instr1),
    .fetch_ready  (fetch_ready),
    .flush        (flush),
    .issue_take   (issue_take),
    .issue_valid1 (issue_valid1),
    .issue_valid2 (issue_valid2),
    .issue_instr1 (issue_instr1),
    .issue_instr2 (issue_instr2),
    .issue_pc1    (issue_pc1),
    .issue_pc2    (issue_pc2),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic [1:0]  take;
    int          exp_count;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t vt[$];
  ent_t mq[$];
  int   nvec;
  int   nerr;

  function automatic logic [31:0] ins0(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  function automatic logic [31:0] ins1(input logic [31:0] pc);
    return 32'h2000_0000 | pc;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare slot outputs against the scoreboard head.
  task automatic check_slots(input string tag);
    int sz;
    sz = mq.size();
    cmp({tag, " valid1"}, 32'(issue_valid1), 32'(sz >= 1));
    cmp({tag, " valid2"}, 32'(issue_valid2), 32'(sz >= 2));
    cmp({tag, " instr1"}, issue_instr1, (sz >= 1) ? mq[0].instr : NOP);
    cmp({tag, " pc1"},    issue_pc1,    (sz >= 1) ? mq[0].pc    : 32'd0);
    cmp({tag, " instr2"}, issue_instr2, (sz >= 2) ? mq[1].instr : NOP);
    cmp({tag, " pc2"},    issue_pc2,    (sz >= 2) ? mq[1].pc    : 32'd0);
    cmp({tag, " sb_count"}, 32'(count), 32'(sz));
  endtask

  // Called just after a rising edge: drive, advance one cycle, update scoreboard.
  task automatic step(input logic fv, input logic [31:0] pc, input logic fl, input logic [1:0] take);
    int   sz;
    int   d;
    logic enq;
    fetch_valid  = fv;
    fetch_pc     = pc;
    fetch_instr0 = ins0(pc);
    fetch_instr1 = ins1(pc);
    flush        = fl;
    issue_take   = take;
    sz  = mq.size();
    enq = fv && ((8 - sz) >= 2) && !fl;
    d   = (take == 2'd0) ? 0 : (take == 2'd1) ? 1 : 2;
    if (d > sz) d = sz;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      for (int k = 0; k < d; k++) void'(mq.pop_front());
      if (enq) begin
        mq.push_back('{pc: pc,         instr: ins0(pc)});
        mq.push_back('{pc: pc + 32'd4, instr: ins1(pc)});
      end
    end
    fetch_valid = 1'b0;
    flush       = 1'b0;
    issue_take  = 2'd0;
  endtask

  function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic fl,
                              input logic [1:0] take, input int c, input logic r);
    vec_t v;
    v.fv = fv; v.pc = pc; v.fl = fl; v.take = take; v.exp_count = c; v.exp_ready = r;
    return v;
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = '0;
    fetch_instr0 = '0;
    fetch_instr1 = '0;
    flush = 1'b0;
    issue_take = 2'd0;

    // fill: 4 pairs to full, 5th held off, then drain 2
    vt.push_back(mk(1, 32'h100, 0, 2'd0, 2, 1));
    vt.push_back(mk(1, 32'h108, 0, 2'd0, 4, 1));
    vt.push_back(mk(1, 32'h110, 0, 2'd0, 6, 1));
    vt.push_back(mk(1, 32'h118, 0, 2'd0, 8, 0));
    vt.push_back(mk(1, 32'h120, 0, 2'd0, 8, 0));
    vt.push_back(mk(1, 32'h120, 0, 2'd2, 6, 1));
    // split issue, then head wraps 7 -> 0 with slot 2 across the wrap
    vt.push_back(mk(0, 32'h0,   0, 2'd1, 5, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd1, 4, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd2, 2, 1));
    vt.push_back(mk(1, 32'h130, 0, 2'd1, 3, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd1, 2, 1));
    vt.push_back(mk(1, 32'h140, 0, 2'd3, 2, 1));
    // simultaneous enqueue + take at count 3, then clipped takes
    vt.push_back(mk(0, 32'h0,   0, 2'd1, 1, 1));
    vt.push_back(mk(1, 32'h150, 0, 2'd0, 3, 1));
    vt.push_back(mk(1, 32'h158, 0, 2'd2, 3, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd2, 1, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd2, 0, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd2, 0, 1));
    // flush at count 5 with enqueue + take active; flushed pair must never appear
    vt.push_back(mk(1, 32'h200, 0, 2'd0, 2, 1));
    vt.push_back(mk(1, 32'h208, 0, 2'd0, 4, 1));
    vt.push_back(mk(1, 32'h210, 0, 2'd1, 5, 1));
    vt.push_back(mk(1, 32'h218, 1, 2'd2, 0, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd0, 0, 1));
    vt.push_back(mk(1, 32'h300, 0, 2'd0, 2, 1));
    vt.push_back(mk(0, 32'h0,   0, 2'd2, 0, 1));

    #12;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cmp("reset count",  32'(count),        32'd0);
    cmp("reset valid1", 32'(issue_valid1), 32'd0);
    cmp("reset valid2", 32'(issue_valid2), 32'd0);
    cmp("reset instr1", issue_instr1,      NOP);
    cmp("reset instr2", issue_instr2,      NOP);
    cmp("reset pc1",    issue_pc1,         32'd0);
    cmp("reset ready",  32'(fetch_ready),  32'd1);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].fv, vt[i].pc, vt[i].fl, vt[i].take);
      cmp($sformatf("vec%0d count", i), 32'(count),       32'(vt[i].exp_count));
      cmp($sformatf("vec%0d ready", i), 32'(fetch_ready), 32'(vt[i].exp_ready));
      check_slots($sformatf("vec%0d", i));
    end

    // Explicit first-pair check independent of the scoreboard.
    step(1, 32'h400, 0, 2'd0);
    cmp("pair instr1", issue_instr1, 32'h1000_0400);
    cmp("pair pc2",    issue_pc2,    32'h0000_0404);

    // Async reset mid-operation returns to empty without waiting for a clock edge.
    step(1, 32'h500, 0, 2'd1);
    rstn = 1'b0;
    #2;
    mq.delete();
    cmp("async rst count",  32'(count),        32'd0);
    cmp("async rst valid1", 32'(issue_valid1), 32'd0);
    cmp("async rst instr1", issue_instr1,      NOP);
    cmp("async rst ready",  32'(fetch_ready),  32'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    step(1, 32'h600, 0, 2'd0);
    check_slots("post rst");
    step(0, 32'h0, 0, 2'd1);
    check_slots("post rst take1");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
